// File: rtl/alu_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_if_pkg
//  Purpose  : Opcode set, FSM state encoding and error byte shared by the
//             ALU <-> UART protocol driver.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_if_pkg;

    localparam logic [5:0] c_OP_ADD = 6'b100000;
    localparam logic [5:0] c_OP_SUB = 6'b100010;
    localparam logic [5:0] c_OP_AND = 6'b100100;
    localparam logic [5:0] c_OP_OR  = 6'b100101;
    localparam logic [5:0] c_OP_XOR = 6'b100110;
    localparam logic [5:0] c_OP_NOR = 6'b100111;
    localparam logic [5:0] c_OP_SRA = 6'b000011;
    localparam logic [5:0] c_OP_SRL = 6'b000010;

    localparam logic [2:0] c_ST_WAIT_A  = 3'd0;
    localparam logic [2:0] c_ST_WAIT_B  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_OP = 3'd2;
    localparam logic [2:0] c_ST_EXEC    = 3'd3;
    localparam logic [2:0] c_ST_SEND    = 3'd4;
    localparam logic [2:0] c_ST_WAIT_TX = 3'd5;

    // Byte returned instead of a result when the opcode byte is rejected
    localparam logic [7:0] c_ERR_CODE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/alu_op_valid.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_valid
//  Purpose  : Combinational check that a received opcode byte names a
//             supported ALU operation. Only built with ALU_IF_OP_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef ALU_IF_OP_CHECK_EN
module alu_op_valid
    import alu_if_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
)
(
    input  logic [NB_DATA-1:0] i_byte,
    output logic               o_valid
);

    logic [NB_OP-1:0] w_op;
    logic             w_upper_zero;
    logic             w_known;

    assign w_op         = i_byte[NB_OP-1:0];
    assign w_upper_zero = ((i_byte >> NB_OP) == '0);

    always_comb begin
        w_known = 1'b0;
        case (w_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_XOR, c_OP_NOR, c_OP_SRA, c_OP_SRL: w_known = 1'b1;
            default:                                w_known = 1'b0;
        endcase
    end

    assign o_valid = w_upper_zero & w_known;

endmodule
`endif
`default_nettype wire

// File: rtl/alu_uart_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_uart_if
//  Purpose  : Collects operand A, operand B and opcode from the UART receiver,
//             drives the combinational ALU, and ships the result to the UART
//             transmitter. Define ALU_IF_OP_CHECK_EN to reject bad opcodes.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_uart_if
    import alu_if_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
)
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_data_A,
    output logic [NB_DATA-1:0] o_alu_data_B,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [NB_DATA-1:0] r_alu_data_a;
    logic [NB_DATA-1:0] r_alu_data_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [NB_DATA-1:0] r_tx_data;
    logic               w_op_accept;

`ifdef ALU_IF_OP_CHECK_EN
    logic r_op_err;

    alu_op_valid #(
        .NB_DATA (NB_DATA),
        .NB_OP   (NB_OP)
    ) u_alu_op_valid (
        .i_byte  (i_rx_data),
        .o_valid (w_op_accept)
    );
`else
    assign w_op_accept = 1'b1;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_WAIT_A:  if (i_rx_done) w_state_next = c_ST_WAIT_B;
            c_ST_WAIT_B:  if (i_rx_done) w_state_next = c_ST_WAIT_OP;
            c_ST_WAIT_OP: if (i_rx_done) w_state_next = c_ST_EXEC;
            c_ST_EXEC:                   w_state_next = c_ST_SEND;
            c_ST_SEND:                   w_state_next = c_ST_WAIT_TX;
            c_ST_WAIT_TX: if (i_tx_done) w_state_next = c_ST_WAIT_A;
            default:                     w_state_next = c_ST_WAIT_A;
        endcase
    end

    // Operand registers are only written on their own capture state, so the
    // ALU inputs stay stable through EXEC and keep their value between frames.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= c_ST_WAIT_A;
            r_alu_data_a <= '0;
            r_alu_data_b <= '0;
            r_alu_op     <= '0;
            r_tx_data    <= '0;
`ifdef ALU_IF_OP_CHECK_EN
            r_op_err     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_WAIT_A && i_rx_done) begin
                r_alu_data_a <= i_rx_data;
            end
            if (r_state == c_ST_WAIT_B && i_rx_done) begin
                r_alu_data_b <= i_rx_data;
            end
            if (r_state == c_ST_WAIT_OP && i_rx_done) begin
                if (w_op_accept) begin
                    r_alu_op <= i_rx_data[NB_OP-1:0];
                end
`ifdef ALU_IF_OP_CHECK_EN
                r_op_err <= ~w_op_accept;
`endif
            end
            if (r_state == c_ST_EXEC) begin
`ifdef ALU_IF_OP_CHECK_EN
                r_tx_data <= r_op_err ? NB_DATA'(c_ERR_CODE) : i_alu_result;
`else
                r_tx_data <= i_alu_result;
`endif
            end
        end
    end

    assign o_alu_data_A = r_alu_data_a;
    assign o_alu_data_B = r_alu_data_b;
    assign o_alu_op     = r_alu_op;
    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = (r_state == c_ST_SEND);
    assign o_busy       = (r_state == c_ST_EXEC) || (r_state == c_ST_SEND) ||
                          (r_state == c_ST_WAIT_TX);

endmodule
`default_nettype wire

// File: tb/tb_alu_uart_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_uart_if
//  Purpose  : Directed self-checking bench for alu_uart_if with a behavioural
//             ALU attached to the operand/opcode outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_uart_if;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_start = 0;

    alu_uart_if #(
        .NB_DATA (8),
        .NB_OP   (6)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_alu_data_A (alu_a),
        .o_alu_data_B (alu_b),
        .o_alu_op     (alu_op),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; unsupported opcodes yield 0
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            6'b100000: alu_result = alu_a + alu_b;
            6'b100010: alu_result = alu_a - alu_b;
            6'b100100: alu_result = alu_a & alu_b;
            6'b100101: alu_result = alu_a | alu_b;
            6'b100110: alu_result = alu_a ^ alu_b;
            6'b100111: alu_result = ~(alu_a | alu_b);
            6'b000011: alu_result = $signed(alu_a) >>> alu_b;
            6'b000010: alu_result = alu_a >> alu_b;
            default:   alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (tx_start) n_start++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Three bytes, then EXEC -> SEND -> WAIT_TX with timing and data checks
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [5:0] exp_op,
                         input logic [7:0] exp_tx);
        int s0;
        s0 = n_start;
        send(a);
        send(b);
        send(op);
        check({tag, " exec busy"}, busy, 1);
        check({tag, " exec no start"}, tx_start, 0);
        check({tag, " A"}, alu_a, a);
        check({tag, " B"}, alu_b, b);
        check({tag, " op"}, alu_op, exp_op);
        tick();
        check({tag, " start"}, tx_start, 1);
        check({tag, " tx_data"}, tx_data, exp_tx);
        tick();
        check({tag, " start gone"}, tx_start, 0);
        check({tag, " wait busy"}, busy, 1);
        check({tag, " one pulse"}, n_start, s0 + 1);
    endtask

    task automatic finish_tx(input string tag, input logic [7:0] exp_tx);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, " idle"}, busy, 0);
        check({tag, " tx_data held"}, tx_data, exp_tx);
    endtask

    initial begin
        int s0;
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst A", alu_a, 0);
        check("rst B", alu_b, 0);
        check("rst op", alu_op, 0);
        check("rst tx_data", tx_data, 0);
        check("rst start", tx_start, 0);
        check("rst busy", busy, 0);

        frame("add", 8'd10, 8'd5, 8'h20, 6'b100000, 8'd15);
        finish_tx("add", 8'd15);

        frame("sub", 8'd15, 8'd5, 8'h22, 6'b100010, 8'd10);
        finish_tx("sub", 8'd10);
        frame("sra", 8'hF0, 8'd2, 8'h03, 6'b000011, 8'hFC);
        finish_tx("sra", 8'hFC);

        // Bytes arriving while a frame is in flight are dropped
        frame("pre-drop", 8'd1, 8'd1, 8'h20, 6'b100000, 8'd2);
        send(8'h55);
        check("drop busy", busy, 1);
        check("drop A kept", alu_a, 1);
        rx_data = 8'h77;
        rx_done = 1'b1;
        tx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("coincident idle", busy, 0);
        check("coincident A kept", alu_a, 1);
        frame("nor", 8'hCC, 8'hAA, 8'h27, 6'b100111, 8'h11);
        finish_tx("nor", 8'h11);

        // tx_done while idle is ignored
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stray tx_done idle", busy, 0);

        // Reset in the middle of collecting a frame
        send(8'h12);
        send(8'h34);
        check("mid busy", busy, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst A", alu_a, 0);
        check("mid rst B", alu_b, 0);
        check("mid rst op", alu_op, 0);
        check("mid rst tx_data", tx_data, 0);
        check("mid rst busy", busy, 0);
        frame("or", 8'd3, 8'd4, 8'h25, 6'b100101, 8'h07);

        // Stalled transmitter: stay in WAIT_TX, no further start pulses
        s0 = n_start;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("stall busy", busy, 1);
            check("stall tx_data", tx_data, 8'h07);
        end
        check("stall pulses", n_start, s0);
        finish_tx("or", 8'h07);

`ifdef ALU_IF_OP_CHECK_EN
        frame("bad op", 8'd1, 8'd2, 8'h3F, 6'b100101, 8'hFF);
        finish_tx("bad op", 8'hFF);
        frame("bad upper", 8'd1, 8'd2, 8'hE0, 6'b100101, 8'hFF);
        finish_tx("bad upper", 8'hFF);
`else
        frame("unk op", 8'd1, 8'd2, 8'h3F, 6'b111111, 8'h00);
        finish_tx("unk op", 8'h00);
        frame("upper bits", 8'd1, 8'd2, 8'hE0, 6'b100000, 8'h03);
        finish_tx("upper bits", 8'h03);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
